// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end defaults and the fetch state encoding
// Contents: ADDR_W_DEF / DATA_W_DEF parameter defaults, FETCH_CNT_W counter
// width, fetch_state_t FSM state enum.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int FETCH_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage with instruction register
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   pc, pc_advance      current pc in, one-cycle increment pulse out
//   flush               redirect, discards in-flight or held instruction
//   imem_req_*/addr     read request to instruction memory (valid/ready)
//   imem_rsp_*          read response (one pulse per accepted request)
//   out_*               instruction handoff to decode (valid/ready)
//   fetch_count         instructions delivered to decode, wrapping
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      pc,
    output logic                   pc_advance,
    input  logic                   flush,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [DATA_W-1:0]      imem_rsp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_instr,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [FETCH_CNT_W-1:0] fetch_count
);

    fetch_state_t            state, state_n;
    logic [ADDR_W-1:0]       fetch_pc;
    logic [DATA_W-1:0]       ir;
    logic [ADDR_W-1:0]       ir_pc;
    logic [FETCH_CNT_W-1:0]  count_q;
    logic                    latch_pc;
    logic                    load_ir;
    logic                    count_en;

    // The address tracks the pc input directly, so a redirect while the
    // request is still unaccepted retargets it without losing a cycle.
    assign imem_addr   = pc;
    assign out_instr   = ir;
    assign out_pc      = ir_pc;
    assign fetch_count = count_q;

    always_comb begin
        state_n        = state;
        imem_req_valid = 1'b0;
        pc_advance     = 1'b0;
        out_valid      = 1'b0;
        latch_pc       = 1'b0;
        load_ir        = 1'b0;
        count_en       = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    latch_pc = 1'b1;
                    // An accepted request cannot be recalled; a flush in the
                    // same cycle must swallow its response instead.
                    state_n  = flush ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush) begin
                        state_n = S_REQ;
                    end else begin
                        pc_advance = 1'b1;
                        load_ir    = 1'b1;
                        state_n    = S_HOLD;
                    end
                end else if (flush) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_n = S_REQ;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                // Flush beats a simultaneous handshake: the held instruction
                // is on the wrong path and must not be counted.
                if (flush) begin
                    state_n = S_REQ;
                end else if (out_ready) begin
                    count_en = 1'b1;
                    state_n  = S_REQ;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            count_q  <= '0;
        end else begin
            state <= state_n;
            if (latch_pc) begin
                fetch_pc <= pc;
            end
            if (load_ir) begin
                ir    <= imem_rsp_data;
                ir_pc <= fetch_pc;
            end
            if (count_en) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] fetch_count;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;
    int   acc_cycle   = 0;
    int   acc_lat     = 0;
    int   delivered   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance), .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .fetch_count(fetch_count)
    );

    // Memory contents as a fixed function of address; address 0 holds 0x1234.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Stimulus: upstream pc register, instruction memory, decode back-pressure.
    initial begin
        int          cnt;
        int          lat;
        logic [15:0] rsp_addr;
        logic        adv_prev;
        cnt = 0; lat = 1; rsp_addr = '0; adv_prev = 1'b0;
        rst = 1'b0; pc = '0; flush = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cycle = k;
            rst   = (k < 2 || (k > 12 && $urandom_range(0, 299) == 0)) ? 1'b0 : 1'b1;
            flush = (k >= 12) && ($urandom_range(0, 15) == 0);
            if (flush) pc = 16'($urandom);
            else if (adv_prev) pc = pc + 16'd1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(rsp_addr);
                end
            end
            if (!rst) cnt = 0;
            imem_req_ready = (k < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready      = (k < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            adv_prev = pc_advance;
            if (rst && imem_req_valid && imem_req_ready) begin
                check("one_outstanding", 32'(cnt), 32'd0);
                lat       = (k < 12) ? 1 : $urandom_range(1, 4);
                cnt       = lat;
                rsp_addr  = imem_addr;
                acc_cycle = k;
                acc_lat   = lat;
                if (!flush) exp_q.push_back(exp_t'{pc, mem_word(pc)});
            end
        end
        @(negedge clk);
        #3;
        check("throughput", 32'(delivered > 100), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: compares DUT outputs with the reference model each cycle.
    initial begin
        logic        prev_rst, prev_ov, prev_or, prev_fl;
        logic [15:0] prev_instr, prev_pc;
        logic [15:0] cnt_model;
        logic        have_rsp;
        logic        exp_adv, exp_ov, delivery;
        int          idle;
        prev_rst = 1'b1; prev_ov = 1'b0; prev_or = 1'b0; prev_fl = 1'b0;
        prev_instr = '0; prev_pc = '0; cnt_model = '0; have_rsp = 1'b0; idle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!prev_rst) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_req_valid", 32'(imem_req_valid), 32'd0);
                check("rst_pc_advance", 32'(pc_advance), 32'd0);
                check("rst_fetch_count", 32'(fetch_count), 32'd0);
                check("rst_out_instr", 32'(out_instr), 32'd0);
                check("rst_out_pc", 32'(out_pc), 32'd0);
            end
            if (rst) begin
                exp_adv = imem_rsp_valid && !flush && exp_q.size() == 1 && !have_rsp;
                exp_ov  = exp_q.size() == 1 && have_rsp;
                check("pc_advance", 32'(pc_advance), 32'(exp_adv));
                check("out_valid", 32'(out_valid), 32'(exp_ov));
                check("fetch_count", 32'(fetch_count), 32'(cnt_model));
                if (imem_req_valid) begin
                    check("imem_addr", 32'(imem_addr), 32'(pc));
                    check("req_while_hold", 32'(out_valid), 32'd0);
                end
                if (out_valid && !prev_ov && prev_rst)
                    check("latency", 32'(cycle - acc_cycle), 32'(acc_lat + 1));
                if (prev_ov && !prev_or && !prev_fl && prev_rst) begin
                    check("hold_instr", 32'(out_instr), 32'(prev_instr));
                    check("hold_pc", 32'(out_pc), 32'(prev_pc));
                end
                delivery = out_valid && out_ready && !flush;
                if (delivery && exp_q.size() > 0) begin
                    check("out_instr", 32'(out_instr), 32'(exp_q[0].data));
                    check("out_pc", 32'(out_pc), 32'(exp_q[0].addr));
                    void'(exp_q.pop_front());
                    cnt_model = cnt_model + 16'd1;
                    have_rsp  = 1'b0;
                    delivered++;
                    idle = 0;
                end
                if (flush) begin
                    exp_q.delete();
                    have_rsp = 1'b0;
                end else if (exp_adv) begin
                    have_rsp = 1'b1;
                end
            end else begin
                exp_q.delete();
                have_rsp  = 1'b0;
                cnt_model = '0;
            end
            idle++;
            if (idle > 400) begin
                check("watchdog_delivery", 32'd0, 32'd1);
                idle = 0;
            end
            prev_rst   = rst;
            prev_ov    = out_valid;
            prev_or    = out_ready;
            prev_fl    = flush;
            prev_instr = out_instr;
            prev_pc    = out_pc;
        end
    end

endmodule
